// File: rtl/int_img_rect_reader.sv
// Rectangle sum reader: fetches up to four corners of the integral and squared-integral
// images and combines them with the four-corner identity into one rectangle sum pair.
`ifndef LAPTOP_WIDTH
`define LAPTOP_WIDTH 640
`endif
`ifndef LAPTOP_HEIGHT
`define LAPTOP_HEIGHT 480
`endif

module int_img_rect_reader #(
    parameter int WIDTH_LIMIT  = `LAPTOP_WIDTH,
    parameter int HEIGHT_LIMIT = `LAPTOP_HEIGHT,
    localparam int CW = $clog2(((WIDTH_LIMIT > HEIGHT_LIMIT) ? WIDTH_LIMIT : HEIGHT_LIMIT) + 1),
    localparam int AW = $clog2(WIDTH_LIMIT * HEIGHT_LIMIT)
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [CW-1:0] req_x,
    input  logic [CW-1:0] req_y,
    input  logic [CW-1:0] req_w,
    input  logic [CW-1:0] req_h,
    output logic          rd_en,
    output logic [AW-1:0] rd_addr,
    input  logic [31:0]   rd_data,
    input  logic [31:0]   rd_data_sq,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [31:0]   rsp_sum,
    output logic [31:0]   rsp_sum_sq,
    output logic          rsp_err
);

    typedef enum logic [1:0] {IDLE, READ, DRAIN, RESP} state_t;

    localparam logic [CW:0] WL  = (CW+1)'(WIDTH_LIMIT);
    localparam logic [CW:0] HL  = (CW+1)'(HEIGHT_LIMIT);
    localparam logic [CW:0] ONE = (CW+1)'(1);

    function automatic logic [AW-1:0] addr_of(input logic [CW:0] row, input logic [CW:0] col);
        return AW'(32'(row) * 32'(WIDTH_LIMIT) + 32'(col));
    endfunction

    state_t        state;
    logic [AW-1:0] lst_addr [4];
    logic [3:0]    lst_sub;
    logic [2:0]    lst_n;
    logic [2:0]    rd_idx;
    logic [2:0]    nxt_idx;
    logic          pend_vld;
    logic          pend_sub;
    logic [31:0]   acc;
    logic [31:0]   acc_sq;
    logic [31:0]   acc_nxt;
    logic [31:0]   acc_sq_nxt;

    logic [CW:0]   x_e, y_e, xw, yh, x2, y2, xm, ym;
    logic          has_x, has_y, illegal;
    logic [AW-1:0] c_addr [4];
    logic [3:0]    c_sub;
    logic [2:0]    c_n;

    // Request decode: build the ordered corner list D, B, C, A with absent terms skipped
    always_comb begin
        x_e     = {1'b0, req_x};
        y_e     = {1'b0, req_y};
        xw      = x_e + {1'b0, req_w};
        yh      = y_e + {1'b0, req_h};
        x2      = xw - ONE;
        y2      = yh - ONE;
        xm      = x_e - ONE;
        ym      = y_e - ONE;
        has_x   = (req_x != '0);
        has_y   = (req_y != '0);
        illegal = (req_w == '0) || (req_h == '0) || (xw > WL) || (yh > HL);
        for (int i = 0; i < 4; i++) begin
            c_addr[i] = addr_of(y2, x2);
        end
        c_sub = '0;
        if (has_y) begin
            c_addr[1] = addr_of(ym, x2);
            c_sub[1]  = 1'b1;
        end
        if (has_x) begin
            if (has_y) begin
                c_addr[2] = addr_of(y2, xm);
                c_sub[2]  = 1'b1;
                c_addr[3] = addr_of(ym, xm);
            end else begin
                c_addr[1] = addr_of(y2, xm);
                c_sub[1]  = 1'b1;
            end
        end
        c_n = 3'd1 + {2'b0, has_y} + {2'b0, has_x} + {2'b0, has_x & has_y};
    end

    assign nxt_idx = rd_idx + 3'd1;

    // Returning word is folded in during the cycle it is present on rd_data
    always_comb begin
        acc_nxt    = acc;
        acc_sq_nxt = acc_sq;
        if (pend_vld) begin
            if (pend_sub) begin
                acc_nxt    = acc - rd_data;
                acc_sq_nxt = acc_sq - rd_data_sq;
            end else begin
                acc_nxt    = acc + rd_data;
                acc_sq_nxt = acc_sq + rd_data_sq;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            req_ready  <= 1'b1;
            rd_en      <= 1'b0;
            rd_addr    <= '0;
            rsp_valid  <= 1'b0;
            rsp_sum    <= '0;
            rsp_sum_sq <= '0;
            rsp_err    <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                lst_addr[i] <= '0;
            end
            lst_sub    <= '0;
            lst_n      <= '0;
            rd_idx     <= '0;
            pend_vld   <= 1'b0;
            pend_sub   <= 1'b0;
            acc        <= '0;
            acc_sq     <= '0;
        end else begin
            pend_vld <= rd_en;
            pend_sub <= lst_sub[rd_idx[1:0]];
            acc      <= acc_nxt;
            acc_sq   <= acc_sq_nxt;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        req_ready <= 1'b0;
                        lst_addr  <= c_addr;
                        lst_sub   <= c_sub;
                        lst_n     <= c_n;
                        rd_idx    <= '0;
                        if (illegal) begin
                            state      <= RESP;
                            rsp_valid  <= 1'b1;
                            rsp_err    <= 1'b1;
                            rsp_sum    <= '0;
                            rsp_sum_sq <= '0;
                        end else begin
                            state   <= READ;
                            rd_en   <= 1'b1;
                            rd_addr <= c_addr[0];
                            rsp_err <= 1'b0;
                        end
                    end
                end
                READ: begin
                    if (nxt_idx < lst_n) begin
                        rd_idx  <= nxt_idx;
                        rd_addr <= lst_addr[nxt_idx[1:0]];
                    end else begin
                        rd_en <= 1'b0;
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    state      <= RESP;
                    rsp_valid  <= 1'b1;
                    rsp_sum    <= acc_nxt;
                    rsp_sum_sq <= acc_sq_nxt;
                end
                RESP: begin
                    if (rsp_ready) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        acc       <= '0;
                        acc_sq    <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_int_img_rect_reader.sv
// Bench for int_img_rect_reader on an 8x6 image of constant pixel value 2.
module tb_int_img_rect_reader;

    localparam int W  = 8;
    localparam int H  = 6;
    localparam int CW = $clog2(((W > H) ? W : H) + 1);
    localparam int AW = $clog2(W * H);

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [CW-1:0] req_x = '0, req_y = '0, req_w = '0, req_h = '0;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [31:0]   rd_data = '0, rd_data_sq = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [31:0]   rsp_sum, rsp_sum_sq;
    logic          rsp_err;

    int checks = 0;
    int errors = 0;

    int mem_i  [W*H];
    int mem_sq [W*H];

    int exp_sum, exp_sq, exp_n;
    bit exp_err;
    int exp_q [$];
    int seen_q [$];
    int last_sum, last_sq, last_err;
    bit armed = 1'b0;
    int lat;

    int_img_rect_reader #(.WIDTH_LIMIT(W), .HEIGHT_LIMIT(H)) dut (
        .clock(clock), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_x(req_x), .req_y(req_y), .req_w(req_w), .req_h(req_h),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_data_sq(rd_data_sq),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_sum(rsp_sum), .rsp_sum_sq(rsp_sum_sq), .rsp_err(rsp_err)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Integral images built by prefix-summing the pixel plane
    initial begin
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                int s, q;
                s = 0; q = 0;
                for (int rr = 0; rr <= r; rr++)
                    for (int cc = 0; cc <= c; cc++) begin
                        s += 2;
                        q += 4;
                    end
                mem_i[r*W+c]  = s;
                mem_sq[r*W+c] = q;
            end
        end
    end

    // One-cycle-latency frame memory
    always @(posedge clock) begin
        if (rd_en) begin
            if (int'(rd_addr) < W*H) begin
                rd_data    <= mem_i[rd_addr];
                rd_data_sq <= mem_sq[rd_addr];
            end else begin
                rd_data    <= 32'hDEAD_BEEF;
                rd_data_sq <= 32'hDEAD_BEEF;
            end
        end
    end

    // Reference: direct pixel sum over the rectangle plus the expected corner address list
    task automatic model_req(input int x, input int y, input int w, input int h);
        exp_q.delete();
        exp_sum = 0;
        exp_sq  = 0;
        exp_err = (w == 0) || (h == 0) || (x + w > W) || (y + h > H);
        if (!exp_err) begin
            for (int r = y; r < y + h; r++)
                for (int c = x; c < x + w; c++) begin
                    exp_sum += 2;
                    exp_sq  += 4;
                end
            exp_q.push_back((y + h - 1) * W + (x + w - 1));
            if (y > 0) exp_q.push_back((y - 1) * W + (x + w - 1));
            if (x > 0) exp_q.push_back((y + h - 1) * W + (x - 1));
            if (x > 0 && y > 0) exp_q.push_back((y - 1) * W + (x - 1));
        end
        exp_n = exp_q.size();
    endtask

    // Per-cycle compare against the model
    always @(negedge clock) begin
        if (reset_n && armed) begin
            if (rd_en) begin
                seen_q.push_back(int'(rd_addr));
                if (exp_q.size() == 0) begin
                    chk("rd_extra", 1, 0);
                end else begin
                    int e;
                    e = exp_q.pop_front();
                    chk("rd_addr", int'(rd_addr), e);
                end
            end
            if (rsp_valid) begin
                chk("rsp_sum", rsp_sum, exp_sum);
                chk("rsp_sum_sq", rsp_sum_sq, exp_sq);
                chk("rsp_err", rsp_err, exp_err);
                chk("req_ready_busy", req_ready, 0);
                last_sum = int'(rsp_sum);
                last_sq  = int'(rsp_sum_sq);
                last_err = int'(rsp_err);
            end
        end
    end

    function automatic int seen_at(input int i);
        return (seen_q.size() > i) ? seen_q[i] : -1;
    endfunction

    task automatic drive(input int x, input int y, input int w, input int h);
        req_x = CW'(x); req_y = CW'(y); req_w = CW'(w); req_h = CW'(h);
    endtask

    task automatic run_req(input int x, input int y, input int w, input int h, input int hold);
        model_req(x, y, w, h);
        seen_q.delete();
        last_sum = -1; last_sq = -1; last_err = -1;
        @(negedge clock);
        chk("req_ready_idle", req_ready, 1);
        drive(x, y, w, h);
        req_valid = 1'b1;
        @(posedge clock);
        #1 req_valid = 1'b0;
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clock);
            if (rsp_valid) begin
                lat = k;
                break;
            end
            chk("rd_en_window", rd_en, (!exp_err && k <= exp_n) ? 1 : 0);
        end
        chk("rsp_latency", lat, exp_err ? 1 : exp_n + 2);
        if (hold > 0) begin
            drive(0, 0, 8, 6);
            req_valid = 1'b1;
            repeat (hold) @(negedge clock);
            chk("rsp_held", rsp_valid, 1);
            req_valid = 1'b0;
        end
        rsp_ready = 1'b1;
        @(posedge clock);
        #1 rsp_ready = 1'b0;
        @(negedge clock);
        chk("rsp_valid_after", rsp_valid, 0);
        chk("req_ready_after", req_ready, 1);
        chk("reads_consumed", exp_q.size(), 0);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_req_ready"}, req_ready, 1);
        chk({tag, "_rd_en"}, rd_en, 0);
        chk({tag, "_rd_addr"}, rd_addr, 0);
        chk({tag, "_rsp_valid"}, rsp_valid, 0);
        chk({tag, "_rsp_sum"}, rsp_sum, 0);
        chk({tag, "_rsp_sum_sq"}, rsp_sum_sq, 0);
        chk({tag, "_rsp_err"}, rsp_err, 0);
    endtask

    initial begin
        repeat (2) @(posedge clock);
        #2 chk_reset_vals("por");
        @(negedge clock);
        reset_n = 1'b1;
        armed   = 1'b1;

        // Model pins on the integral images
        chk("pin_I_2_3", mem_i[19], 24);
        chk("pin_Isq_5_7", mem_sq[47], 192);

        // Interior rectangle: all four corners
        run_req(1, 1, 3, 2, 0);
        chk("t1_lat", lat, 6);
        chk("t1_nreads", seen_q.size(), 4);
        chk("t1_a0", seen_at(0), 19);
        chk("t1_a1", seen_at(1), 3);
        chk("t1_a2", seen_at(2), 16);
        chk("t1_a3", seen_at(3), 0);
        chk("t1_sum", last_sum, 12);
        chk("t1_sq", last_sq, 24);
        chk("t1_err", last_err, 0);

        // Full frame: single corner
        run_req(0, 0, 8, 6, 0);
        chk("t2_lat", lat, 3);
        chk("t2_nreads", seen_q.size(), 1);
        chk("t2_a0", seen_at(0), 47);
        chk("t2_sum", last_sum, 96);
        chk("t2_sq", last_sq, 192);

        // Left edge: D and B only
        run_req(0, 2, 2, 2, 0);
        chk("t3_nreads", seen_q.size(), 2);
        chk("t3_a0", seen_at(0), 25);
        chk("t3_a1", seen_at(1), 9);
        chk("t3_sum", last_sum, 8);
        chk("t3_sq", last_sq, 16);

        // Top edge: D and C only
        run_req(3, 0, 2, 3, 0);
        chk("t3b_nreads", seen_q.size(), 2);
        chk("t3b_sum", last_sum, 12);

        // Illegal requests
        run_req(6, 0, 3, 1, 0);
        chk("t4_lat", lat, 1);
        chk("t4_nreads", seen_q.size(), 0);
        chk("t4_err", last_err, 1);
        chk("t4_sum", last_sum, 0);
        run_req(2, 2, 0, 1, 0);
        chk("t5_lat", lat, 1);
        chk("t5_err", last_err, 1);
        run_req(0, 5, 1, 2, 0);
        chk("t5b_err", last_err, 1);

        // Back-pressure with a competing request pending
        run_req(1, 1, 3, 2, 5);
        chk("t6_sum", last_sum, 12);
        chk("t6_nreads", seen_q.size(), 4);
        run_req(2, 3, 4, 3, 0);
        chk("t7_sum", last_sum, 24);
        chk("t7_sq", last_sq, 48);

        // Reset in the middle of READ
        model_req(1, 1, 3, 2);
        @(negedge clock);
        drive(1, 1, 3, 2);
        req_valid = 1'b1;
        @(posedge clock);
        #1 req_valid = 1'b0;
        @(negedge clock);
        @(negedge clock);
        chk("mid_rd_en", rd_en, 1);
        #2 armed = 1'b0;
        reset_n = 1'b0;
        #1 chk_reset_vals("mid");
        exp_q.delete();
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        armed   = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clock);
            chk("post_rst_idle_rsp", rsp_valid, 0);
            chk("post_rst_idle_rd", rd_en, 0);
        end
        run_req(1, 1, 3, 2, 0);
        chk("t8_sum", last_sum, 12);
        chk("t8_sq", last_sq, 24);
        chk("t8_lat", lat, 6);

        repeat (2) @(negedge clock);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
